// File: rtl/ddr_fetch_pkg.sv
// ddr_fetch_pkg: shared FSM state type and address helpers for the DDR line fetcher.
package ddr_fetch_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} fetch_state_e;
    localparam int unsigned WORD_BYTES = 4;
    function automatic int unsigned frame_bytes(input int unsigned line_pixels, input int unsigned num_lines);
        return line_pixels * WORD_BYTES * num_lines;
    endfunction
endpackage

// File: rtl/dpram.sv
// dpram: simple dual-port RAM, one write port and one registered read port.
module dpram #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk_sys,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk_sys) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/ddr_line_fetcher.sv
// ddr_line_fetcher: fetches display lines from DDR into a ping-pong line buffer.
// Define LINE_FETCH_STATS_EN to implement the saturating underrun counter.
module ddr_line_fetcher
    import ddr_fetch_pkg::*;
#(
    parameter int LINE_PIXELS = 512,
    parameter int NUM_LINES   = 480,
    parameter int NUM_FRAMES  = 128,
    parameter int ADDR_W      = 28
) (
    input  logic                           clk_sys,
    input  logic                           reset_n,
    input  logic                           frame_start,
    input  logic                           line_start,
    input  logic                           loop_en,
    input  logic [ADDR_W-1:0]              frame_base,
    input  logic                           step_fwd,
    input  logic                           step_back,
    output logic [ADDR_W-1:0]              ddr_addr,
    output logic                           ddr_req,
    input  logic                           ddr_ready,
    input  logic [31:0]                    ddr_dout,
    input  logic [$clog2(LINE_PIXELS)-1:0] pix_addr,
    output logic [31:0]                    pix_data,
    output logic [$clog2(NUM_FRAMES)-1:0]  frame_idx,
    output logic                           underrun,
    output logic [15:0]                    underrun_cnt
);
    localparam int PW = $clog2(LINE_PIXELS);
    localparam int LW = $clog2(NUM_LINES);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam logic [ADDR_W-1:0] FB = ADDR_W'(frame_bytes(LINE_PIXELS, NUM_LINES));
    localparam logic [ADDR_W-1:0] LB = ADDR_W'(LINE_PIXELS * WORD_BYTES);
    localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);
    localparam logic [LW-1:0] LAST_LINE = LW'(NUM_LINES - 1);
    localparam logic [PW-1:0] LAST_WORD = PW'(LINE_PIXELS - 1);

    fetch_state_e state, state_n;
    logic [FW-1:0] idx_n;
    logic [LW-1:0] line_q, line_n;
    logic [PW-1:0] word_q, word_n;
    logic disp_q, disp_n, pend_q, pend_n, load, wr_seen, beat, ur_hit;
    logic [ADDR_W-1:0] addr_n;
    logic [31:0] rd_data;

    assign ddr_req = state != ST_IDLE;
    assign beat = state == ST_WAIT && ddr_ready;
    assign ur_hit = ddr_req && line_start;
    assign pix_data = wr_seen ? rd_data : '0;
    assign addr_n = frame_base + ADDR_W'(idx_n) * FB + ADDR_W'(line_n) * LB + ADDR_W'(word_n) * ADDR_W'(WORD_BYTES);

    always_comb begin
        idx_n = frame_idx;
        if (frame_start) idx_n = frame_idx == LAST_FRAME ? (loop_en ? '0 : frame_idx) : frame_idx + 1'b1;
        else if (step_fwd && !step_back) idx_n = frame_idx == LAST_FRAME ? '0 : frame_idx + 1'b1;
        else if (step_back && !step_fwd) idx_n = frame_idx == '0 ? LAST_FRAME : frame_idx - 1'b1;
    end

    // frame_start while busy only marks a restart; the outstanding word always completes
    always_comb begin
        state_n = state;
        line_n = frame_start ? '0 : line_q;
        disp_n = frame_start ? 1'b0 : disp_q;
        word_n = word_q;
        pend_n = pend_q | frame_start;
        load = 1'b0;
        case (state)
            ST_IDLE: begin
                pend_n = 1'b0;
                if (frame_start) begin
                    word_n = '0;
                    state_n = ST_REQ;
                    load = 1'b1;
                end else if (line_start) begin
                    disp_n = ~disp_q;
                    line_n = line_q + 1'b1;
                    if (line_q != LAST_LINE) begin
                        word_n = '0;
                        state_n = ST_REQ;
                        load = 1'b1;
                    end
                end
            end
            ST_REQ: state_n = ST_WAIT;
            default: if (ddr_ready) begin
                if (pend_q || frame_start) begin
                    pend_n = 1'b0;
                    word_n = '0;
                    state_n = ST_REQ;
                    load = 1'b1;
                end else if (word_q == LAST_WORD) begin
                    state_n = ST_IDLE;
                end else begin
                    word_n = word_q + 1'b1;
                    state_n = ST_REQ;
                    load = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            ddr_addr <= '0;
            frame_idx <= '0;
            line_q <= '0;
            word_q <= '0;
            disp_q <= 1'b0;
            pend_q <= 1'b0;
            underrun <= 1'b0;
            wr_seen <= 1'b0;
        end else begin
            state <= state_n;
            ddr_addr <= load ? addr_n : ddr_addr;
            frame_idx <= idx_n;
            line_q <= line_n;
            word_q <= word_n;
            disp_q <= disp_n;
            pend_q <= pend_n;
            underrun <= underrun | ur_hit;
            wr_seen <= wr_seen | beat;
        end
    end

`ifdef LINE_FETCH_STATS_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) underrun_cnt <= '0;
        else if (ur_hit && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
    end
`else
    assign underrun_cnt = '0;
`endif

    dpram #(.AW(PW + 1), .DW(32)) u_line_buf (
        .clk_sys(clk_sys),
        .we     (beat),
        .waddr  ({~disp_q, word_q}),
        .wdata  (ddr_dout),
        .raddr  ({disp_q, pix_addr}),
        .rdata  (rd_data)
    );
endmodule

// File: doc/ddr_line_fetcher.md
DDR_LINE_FETCHER -- requirements
Module: ddr_line_fetcher

Interface
REQ-001 Parameter LINE_PIXELS, default 512, 32-bit words per line.
REQ-002 Parameter NUM_LINES, default 480, lines per frame.
REQ-003 Parameter NUM_FRAMES, default 128, frames in the DDR sequence.
REQ-004 Parameter ADDR_W, default 28, DDR byte-address width.
REQ-005 Port clk_sys, input, 1: the only clock; every register is clocked on its rising edge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port frame_start, input, 1: one-cycle pulse at the vsync rising edge.
REQ-008 Port line_start, input, 1: one-cycle pulse at the end of each active line.
REQ-009 Port loop_en, input, 1: 1 = frame index wraps, 0 = index holds at the last frame.
REQ-010 Port frame_base, input, ADDR_W: byte address of frame 0.
REQ-011 Port step_fwd / step_back, input, 1 each: pulses that move the frame index by +1 / -1.
REQ-012 Port ddr_addr, output, ADDR_W: byte address of the word being requested.
REQ-013 Port ddr_req, output, 1: read request.
REQ-014 Port ddr_ready, input, 1: one-cycle pulse; ddr_dout is valid in the same cycle.
REQ-015 Port ddr_dout, input, 32: read data in {a,r,g,b} order.
REQ-016 Port pix_addr, input, log2(LINE_PIXELS): display read index.
REQ-017 Port pix_data, output, 32: display bank word.
REQ-018 Port frame_idx, output, log2(NUM_FRAMES): current frame index.
REQ-019 Port underrun, output, 1: sticky flag; cleared only by reset.
REQ-020 Port underrun_cnt, output, 16: underrun count.

Function
REQ-021 The block SHALL implement the FSM states IDLE -> REQ -> WAIT -> (REQ | IDLE).
- REQ: asserts ddr_req and loads ddr_addr.
- WAIT: holds ddr_req high until ddr_ready, then writes ddr_dout into the fetch bank.
- After the word with index LINE_PIXELS-1 is written, the FSM returns to IDLE.
REQ-022 Line buffer: 2 x LINE_PIXELS words, ping-pong.
- fetch bank = ~display bank.
- pix_data = word at {display bank, pix_addr}, latency 1 cycle.
REQ-023 line_start while in IDLE SHALL:
- swap the banks;
- increment the line counter;
- start fetching the next line, unless the line just displayed was NUM_LINES-1, in which case no fetch starts.
REQ-024 line_start while not in IDLE SHALL set underrun and increment underrun_cnt; the banks do not swap and the fetch in progress continues.
REQ-025 Word address = frame_base + frame_idx*FRAME_BYTES + line*LINE_PIXELS*4 + word*4.
- FRAME_BYTES = LINE_PIXELS*4*NUM_LINES.
- Arithmetic is done at ADDR_W bits; overflow wraps modulo 2^ADDR_W.
REQ-026 frame_start SHALL:
- advance frame_idx by 1;
- at NUM_FRAMES-1: wrap to 0 if loop_en = 1, otherwise hold at NUM_FRAMES-1;
- reset the line counter to 0 and the display bank to 0;
- start prefetching line 0 into bank 1.
REQ-027 frame_start arriving during REQ or WAIT SHALL set a pending flag.
- The outstanding word completes; ddr_req is never dropped before ddr_ready.
- The fetch then restarts at line 0 of the new frame.
REQ-028 step_fwd / step_back SHALL change frame_idx by ±1, wrapping modulo NUM_FRAMES in both directions, regardless of loop_en.
REQ-029 Simultaneous step_fwd and step_back SHALL leave frame_idx unchanged.
REQ-030 frame_start SHALL take priority over step_fwd / step_back in the same cycle; the steps in that cycle are ignored.
REQ-031 underrun_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-032 While reset_n = 0 the block SHALL force:
- FSM = IDLE; ddr_req = 0; ddr_addr = 0;
- frame_idx = 0; line counter = 0; display bank = 0;
- underrun = 0; underrun_cnt = 0; pending flag = 0.
REQ-033 pix_data SHALL be 0 after reset until the first bank write; line-buffer contents are otherwise undefined.
REQ-034 Reset asserted mid-fetch SHALL drop ddr_req immediately; the DDR arbiter's outstanding transaction is discarded.

Configuration
REQ-035 With LINE_FETCH_STATS_EN defined, underrun_cnt SHALL be implemented as specified above.
REQ-036 Without LINE_FETCH_STATS_EN, underrun_cnt SHALL be tied to 0; the sticky underrun flag remains implemented.

Structure
REQ-037 Shared package ddr_fetch_pkg SHALL hold:
- the FSM state enum;
- the WORD_BYTES = 4 constant;
- a FRAME_BYTES function of (LINE_PIXELS, NUM_LINES).
REQ-038 The line buffer SHALL be one instance of the existing dpram module: address width log2(LINE_PIXELS)+1, data width 32.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- LINE_PIXELS=8, NUM_LINES=4, frame_base=0x1000, frame_start at frame_idx 0 -> frame_idx=1; ddr_addr sequence 0x1080..0x109C; ddr_ready delay 3 cycles.
- line_start at the 6th ddr_ready of a line -> underrun=1, underrun_cnt=1, banks not swapped.
- loop_en=0 with frame_idx=NUM_FRAMES-1, frame_start -> frame_idx holds; loop_en=1 -> frame_idx=0.
- step_back at frame_idx 0 -> frame_idx=NUM_FRAMES-1; step_fwd and step_back in the same cycle -> no change.
- frame_start during WAIT -> ddr_req held until ddr_ready, then next ddr_addr = frame_base + new_idx*FRAME_BYTES.
- reset_n low during WAIT -> ddr_req=0 in the same cycle; all outputs at reset values; rebuild without the macro -> underrun_cnt always 0.
